// File: rtl/pyrm_memory_block.sv
// pyrm RV64I memory-access stage: issues aligned data-memory requests, aligns and
// extends load results, passes ALU results through, and reports bad accesses.
module pyrm_memory_block (
  input  logic        clk,
  input  logic        reset_pyri,
  input  logic [63:0] pc_pyri,
  input  logic        pc_valid_pyri,
  output logic        pc_retry_pyro,
  input  logic [31:0] inst_pyri,
  input  logic        inst_valid_pyri,
  output logic        inst_retry_pyro,
  input  logic [63:0] rdata_pyri,
  input  logic        rdata_valid_pyri,
  output logic        rdata_retry_pyro,
  input  logic [63:0] raddr_pyri,
  input  logic        raddr_valid_pyri,
  output logic        raddr_retry_pyro,
  output logic [63:0] dmem_addr_pyro,
  output logic [63:0] dmem_wdata_pyro,
  output logic [7:0]  dmem_wmask_pyro,
  output logic        dmem_we_pyro,
  output logic        dmem_req_valid_pyro,
  input  logic        dmem_req_retry_pyri,
  input  logic [63:0] dmem_resp_data_pyri,
  input  logic        dmem_resp_valid_pyri,
  output logic        dmem_resp_retry_pyro,
  output logic [63:0] wb_data_pyro,
  output logic [4:0]  wb_rd_pyro,
  output logic        wb_valid_pyro,
  input  logic        wb_retry_pyri,
  output logic [63:0] exc_pc_pyro,
  output logic [63:0] exc_addr_pyro,
  output logic        exc_valid_pyro,
  input  logic        exc_retry_pyri
);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, OUT, EXC} state_t;
  state_t state, state_nx;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        is_branch, is_load, is_store, is_mem;
  logic        chan_ok, accept;
  logic [63:0] acc_addr;
  logic [2:0]  off, align_mask;
  logic [7:0]  base_mask;
  logic        malformed, misaligned, fault;
  logic [2:0]  ld_funct3;
  logic [2:0]  ld_off;
  logic [63:0] shifted, load_result;
  logic        unused_bits;

  assign unused_bits = ^{inst_pyri[31:15], inst_pyri[11:7]};

  assign opcode    = inst_pyri[6:0];
  assign funct3    = inst_pyri[14:12];
  assign is_branch = (opcode == 7'b1100011);
  assign is_load   = (opcode == 7'b0000011);
  assign is_store  = (opcode == 7'b0100011);
  assign is_mem    = is_load | is_store;

  // Branches need only pc+inst; everything else needs all four channels together.
  assign chan_ok = pc_valid_pyri & inst_valid_pyri &
                   (is_branch | (rdata_valid_pyri & raddr_valid_pyri));
  assign accept  = (state == IDLE) & ~reset_pyri & chan_ok;

  assign pc_retry_pyro    = ~accept;
  assign inst_retry_pyro  = ~accept;
  assign rdata_retry_pyro = ~(accept & ~is_branch);
  assign raddr_retry_pyro = ~(accept & ~is_branch);

  assign acc_addr = is_load ? rdata_pyri : raddr_pyri;
  assign off      = acc_addr[2:0];

  always_comb begin
    align_mask = 3'b000;
    base_mask  = 8'h01;
    case (funct3[1:0])
      2'b00: begin align_mask = 3'b000; base_mask = 8'h01; end
      2'b01: begin align_mask = 3'b001; base_mask = 8'h03; end
      2'b10: begin align_mask = 3'b011; base_mask = 8'h0F; end
      default: begin align_mask = 3'b111; base_mask = 8'hFF; end
    endcase
  end

  assign malformed  = (is_load & (funct3 == 3'b111)) | (is_store & funct3[2]);
  assign misaligned = |(off & align_mask);
  assign fault      = is_mem & (malformed | misaligned);

  assign shifted = dmem_resp_data_pyri >> {ld_off, 3'b000};
  always_comb begin
    load_result = shifted;
    case (ld_funct3)
      3'b000: load_result = {{56{shifted[7]}},  shifted[7:0]};
      3'b001: load_result = {{48{shifted[15]}}, shifted[15:0]};
      3'b010: load_result = {{32{shifted[31]}}, shifted[31:0]};
      3'b100: load_result = {56'd0, shifted[7:0]};
      3'b101: load_result = {48'd0, shifted[15:0]};
      3'b110: load_result = {32'd0, shifted[31:0]};
      default: load_result = shifted;
    endcase
  end

  always_ff @(posedge clk or posedge reset_pyri) begin
    if (reset_pyri) state <= IDLE;
    else            state <= state_nx;
  end

  always_comb begin
    state_nx             = state;
    dmem_req_valid_pyro  = 1'b0;
    dmem_resp_retry_pyro = 1'b1;
    wb_valid_pyro        = 1'b0;
    exc_valid_pyro       = 1'b0;
    case (state)
      IDLE: if (accept && !is_branch) begin
        if (fault)       state_nx = EXC;
        else if (is_mem) state_nx = REQ;
        else             state_nx = OUT;
      end
      REQ: begin
        dmem_req_valid_pyro = 1'b1;
        if (!dmem_req_retry_pyri) state_nx = dmem_we_pyro ? IDLE : WAIT;
      end
      WAIT: begin
        dmem_resp_retry_pyro = 1'b0;
        if (dmem_resp_valid_pyri) state_nx = OUT;
      end
      OUT: begin
        wb_valid_pyro = 1'b1;
        if (!wb_retry_pyri) state_nx = IDLE;
      end
      EXC: begin
        exc_valid_pyro = 1'b1;
        if (!exc_retry_pyri) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset_pyri) begin
    if (reset_pyri) begin
      dmem_addr_pyro  <= '0;
      dmem_wdata_pyro <= '0;
      dmem_wmask_pyro <= '0;
      dmem_we_pyro    <= 1'b0;
      wb_data_pyro    <= '0;
      wb_rd_pyro      <= '0;
      exc_pc_pyro     <= '0;
      exc_addr_pyro   <= '0;
      ld_funct3       <= '0;
      ld_off          <= '0;
    end else begin
      if (accept && !is_branch) begin
        if (fault) begin
          exc_pc_pyro   <= pc_pyri;
          exc_addr_pyro <= acc_addr;
        end else if (is_mem) begin
          dmem_addr_pyro  <= {acc_addr[63:3], 3'b000};
          dmem_we_pyro    <= is_store;
          dmem_wmask_pyro <= is_store ? 8'(base_mask << off) : 8'h00;
          dmem_wdata_pyro <= is_store ? (rdata_pyri << {off, 3'b000}) : 64'd0;
          ld_funct3       <= funct3;
          ld_off          <= off;
          if (is_load) wb_rd_pyro <= raddr_pyri[4:0];
        end else begin
          wb_data_pyro <= rdata_pyri;
          wb_rd_pyro   <= raddr_pyri[4:0];
        end
      end
      if (state == WAIT && dmem_resp_valid_pyri) wb_data_pyro <= load_result;
    end
  end

endmodule

// File: tb/tb_pyrm_memory_block.sv
// Directed bench for pyrm_memory_block: pass-through, loads, stores, exceptions,
// branches, backpressure and mid-transaction reset.
module tb_pyrm_memory_block;
  logic        clk = 1'b0;
  logic        reset_pyri;
  logic [63:0] pc_pyri;
  logic        pc_valid_pyri, pc_retry_pyro;
  logic [31:0] inst_pyri;
  logic        inst_valid_pyri, inst_retry_pyro;
  logic [63:0] rdata_pyri;
  logic        rdata_valid_pyri, rdata_retry_pyro;
  logic [63:0] raddr_pyri;
  logic        raddr_valid_pyri, raddr_retry_pyro;
  logic [63:0] dmem_addr_pyro, dmem_wdata_pyro;
  logic [7:0]  dmem_wmask_pyro;
  logic        dmem_we_pyro, dmem_req_valid_pyro, dmem_req_retry_pyri;
  logic [63:0] dmem_resp_data_pyri;
  logic        dmem_resp_valid_pyri, dmem_resp_retry_pyro;
  logic [63:0] wb_data_pyro;
  logic [4:0]  wb_rd_pyro;
  logic        wb_valid_pyro, wb_retry_pyri;
  logic [63:0] exc_pc_pyro, exc_addr_pyro;
  logic        exc_valid_pyro, exc_retry_pyri;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  pyrm_memory_block dut (
    .clk(clk), .reset_pyri(reset_pyri),
    .pc_pyri(pc_pyri), .pc_valid_pyri(pc_valid_pyri), .pc_retry_pyro(pc_retry_pyro),
    .inst_pyri(inst_pyri), .inst_valid_pyri(inst_valid_pyri), .inst_retry_pyro(inst_retry_pyro),
    .rdata_pyri(rdata_pyri), .rdata_valid_pyri(rdata_valid_pyri), .rdata_retry_pyro(rdata_retry_pyro),
    .raddr_pyri(raddr_pyri), .raddr_valid_pyri(raddr_valid_pyri), .raddr_retry_pyro(raddr_retry_pyro),
    .dmem_addr_pyro(dmem_addr_pyro), .dmem_wdata_pyro(dmem_wdata_pyro),
    .dmem_wmask_pyro(dmem_wmask_pyro), .dmem_we_pyro(dmem_we_pyro),
    .dmem_req_valid_pyro(dmem_req_valid_pyro), .dmem_req_retry_pyri(dmem_req_retry_pyri),
    .dmem_resp_data_pyri(dmem_resp_data_pyri), .dmem_resp_valid_pyri(dmem_resp_valid_pyri),
    .dmem_resp_retry_pyro(dmem_resp_retry_pyro),
    .wb_data_pyro(wb_data_pyro), .wb_rd_pyro(wb_rd_pyro), .wb_valid_pyro(wb_valid_pyro),
    .wb_retry_pyri(wb_retry_pyri),
    .exc_pc_pyro(exc_pc_pyro), .exc_addr_pyro(exc_addr_pyro), .exc_valid_pyro(exc_valid_pyro),
    .exc_retry_pyri(exc_retry_pyri)
  );

  function automatic logic [31:0] enc(input logic [6:0] op, input logic [2:0] f3);
    return {17'd0, f3, 5'd0, op};
  endfunction

  // Drive an instruction on the input channels (called just after a negedge).
  task automatic present(input logic [63:0] p, input logic [31:0] i,
                         input logic [63:0] rd, input logic [63:0] ra, input bit all4);
    pc_pyri = p; inst_pyri = i; rdata_pyri = rd; raddr_pyri = ra;
    pc_valid_pyri = 1'b1; inst_valid_pyri = 1'b1;
    rdata_valid_pyri = all4; raddr_valid_pyri = all4;
  endtask

  task automatic idle_inputs();
    pc_valid_pyri = 1'b0; inst_valid_pyri = 1'b0;
    rdata_valid_pyri = 1'b0; raddr_valid_pyri = 1'b0;
  endtask

  task automatic test_reset();
    reset_pyri = 1'b1;
    present(64'h40, enc(7'b0110011, 3'd0), 64'h1, 64'h1, 1'b1);
    @(negedge clk); #1;
    total++; if (inst_retry_pyro !== 1'b1 || rdata_retry_pyro !== 1'b1 || pc_retry_pyro !== 1'b1)
      begin bad++; $display("FAIL reset_retry got=%b%b%b exp=111", pc_retry_pyro, inst_retry_pyro, rdata_retry_pyro); end
    total++; if ({dmem_req_valid_pyro, wb_valid_pyro, exc_valid_pyro, dmem_we_pyro} !== 4'b0000)
      begin bad++; $display("FAIL reset_valids got=%b exp=0000", {dmem_req_valid_pyro, wb_valid_pyro, exc_valid_pyro, dmem_we_pyro}); end
    total++; if (dmem_addr_pyro !== 64'd0 || wb_data_pyro !== 64'd0 || exc_addr_pyro !== 64'd0 || dmem_wmask_pyro !== 8'd0)
      begin bad++; $display("FAIL reset_payload got=%h/%h/%h exp=0", dmem_addr_pyro, wb_data_pyro, exc_addr_pyro); end
    total++; if (dmem_resp_retry_pyro !== 1'b1)
      begin bad++; $display("FAIL reset_resp_retry got=%b exp=1", dmem_resp_retry_pyro); end
    idle_inputs();
    reset_pyri = 1'b0;
  endtask

  task automatic test_add(input logic [63:0] val, input logic [63:0] rd);
    @(negedge clk);
    present(64'h100, enc(7'b0110011, 3'd0), val, rd, 1'b1);
    #1;
    total++; if (rdata_retry_pyro !== 1'b0 || inst_retry_pyro !== 1'b0)
      begin bad++; $display("FAIL add_accept got=%b%b exp=00", inst_retry_pyro, rdata_retry_pyro); end
    @(negedge clk); idle_inputs();
    total++; if (wb_valid_pyro !== 1'b1 || wb_data_pyro !== val || wb_rd_pyro !== rd[4:0])
      begin bad++; $display("FAIL add_wb got=%b %h %0d exp=1 %h %0d", wb_valid_pyro, wb_data_pyro, wb_rd_pyro, val, rd[4:0]); end
    total++; if (dmem_req_valid_pyro !== 1'b0)
      begin bad++; $display("FAIL add_no_req got=%b exp=0", dmem_req_valid_pyro); end
    @(negedge clk);
    total++; if (wb_valid_pyro !== 1'b0)
      begin bad++; $display("FAIL add_wb_done got=%b exp=0", wb_valid_pyro); end
  endtask

  task automatic test_load(input logic [2:0] f3, input logic [63:0] addr,
                           input logic [63:0] mem, input logic [63:0] exp_data);
    @(negedge clk);
    present(64'h200, enc(7'b0000011, f3), addr, 64'd7, 1'b1);
    #1;
    total++; if (raddr_retry_pyro !== 1'b0)
      begin bad++; $display("FAIL load_accept got=%b exp=0", raddr_retry_pyro); end
    @(negedge clk); idle_inputs();
    total++; if (dmem_req_valid_pyro !== 1'b1 || dmem_addr_pyro !== (addr & ~64'd7) || dmem_wmask_pyro !== 8'h00 || dmem_we_pyro !== 1'b0)
      begin bad++; $display("FAIL load_req got=%b %h %h %b exp=1 %h 00 0", dmem_req_valid_pyro, dmem_addr_pyro, dmem_wmask_pyro, dmem_we_pyro, addr & ~64'd7); end
    @(negedge clk);
    total++; if (dmem_resp_retry_pyro !== 1'b0 || dmem_req_valid_pyro !== 1'b0)
      begin bad++; $display("FAIL load_wait got=%b %b exp=0 0", dmem_resp_retry_pyro, dmem_req_valid_pyro); end
    dmem_resp_valid_pyri = 1'b1; dmem_resp_data_pyri = mem;
    @(negedge clk); dmem_resp_valid_pyri = 1'b0;
    total++; if (wb_valid_pyro !== 1'b1 || wb_data_pyro !== exp_data || wb_rd_pyro !== 5'd7)
      begin bad++; $display("FAIL load_wb f3=%0d got=%b %h %0d exp=1 %h 7", f3, wb_valid_pyro, wb_data_pyro, wb_rd_pyro, exp_data); end
    @(negedge clk);
  endtask

  task automatic test_store_sh();
    @(negedge clk);
    present(64'h300, enc(7'b0100011, 3'b001), 64'hABCD, 64'h2006, 1'b1);
    @(negedge clk); idle_inputs();
    total++; if (dmem_req_valid_pyro !== 1'b1 || dmem_addr_pyro !== 64'h2000 || dmem_we_pyro !== 1'b1)
      begin bad++; $display("FAIL sh_req got=%b %h %b exp=1 2000 1", dmem_req_valid_pyro, dmem_addr_pyro, dmem_we_pyro); end
    total++; if (dmem_wmask_pyro !== 8'hC0 || dmem_wdata_pyro !== 64'hABCD_0000_0000_0000)
      begin bad++; $display("FAIL sh_lane got=%h %h exp=c0 abcd000000000000", dmem_wmask_pyro, dmem_wdata_pyro); end
    @(negedge clk);
    total++; if (dmem_req_valid_pyro !== 1'b0 || wb_valid_pyro !== 1'b0 || inst_retry_pyro !== 1'b1)
      begin bad++; $display("FAIL sh_done got=%b %b %b exp=0 0 1", dmem_req_valid_pyro, wb_valid_pyro, inst_retry_pyro); end
  endtask

  task automatic test_exception(input logic [6:0] op, input logic [2:0] f3,
                                input logic [63:0] rd, input logic [63:0] ra, input logic [63:0] exp_addr);
    @(negedge clk);
    present(64'h400, enc(op, f3), rd, ra, 1'b1);
    @(negedge clk); idle_inputs();
    total++; if (exc_valid_pyro !== 1'b1 || exc_addr_pyro !== exp_addr || exc_pc_pyro !== 64'h400)
      begin bad++; $display("FAIL exc got=%b %h %h exp=1 %h 400", exc_valid_pyro, exc_addr_pyro, exc_pc_pyro, exp_addr); end
    total++; if (dmem_req_valid_pyro !== 1'b0 || wb_valid_pyro !== 1'b0)
      begin bad++; $display("FAIL exc_no_req got=%b %b exp=0 0", dmem_req_valid_pyro, wb_valid_pyro); end
    @(negedge clk);
    total++; if (exc_valid_pyro !== 1'b0 || dmem_req_valid_pyro !== 1'b0)
      begin bad++; $display("FAIL exc_done got=%b %b exp=0 0", exc_valid_pyro, dmem_req_valid_pyro); end
  endtask

  task automatic test_branch();
    @(negedge clk);
    present(64'h500, enc(7'b1100011, 3'd0), 64'd0, 64'd0, 1'b0);
    #1;
    total++; if ({pc_retry_pyro, inst_retry_pyro, rdata_retry_pyro, raddr_retry_pyro} !== 4'b0011)
      begin bad++; $display("FAIL beq_retry got=%b exp=0011", {pc_retry_pyro, inst_retry_pyro, rdata_retry_pyro, raddr_retry_pyro}); end
    @(negedge clk); idle_inputs();
    total++; if ({wb_valid_pyro, exc_valid_pyro, dmem_req_valid_pyro} !== 3'b000)
      begin bad++; $display("FAIL beq_quiet got=%b exp=000", {wb_valid_pyro, exc_valid_pyro, dmem_req_valid_pyro}); end
    test_add(64'h55, 64'd3);
  endtask

  task automatic test_backpressure();
    // wb stall with the next instruction already waiting on the inputs
    wb_retry_pyri = 1'b1;
    @(negedge clk);
    present(64'h600, enc(7'b0110011, 3'd0), 64'hCAFE, 64'd9, 1'b1);
    @(negedge clk);
    present(64'h604, enc(7'b0110011, 3'd0), 64'hBEEF, 64'd10, 1'b1);
    for (int i = 0; i < 5; i++) begin
      total++; if (wb_valid_pyro !== 1'b1 || wb_data_pyro !== 64'hCAFE || wb_rd_pyro !== 5'd9 || inst_retry_pyro !== 1'b1 || rdata_retry_pyro !== 1'b1)
        begin bad++; $display("FAIL wb_stall cyc=%0d got=%b %h %0d %b exp=1 cafe 9 1", i, wb_valid_pyro, wb_data_pyro, wb_rd_pyro, inst_retry_pyro); end
      if (i == 4) wb_retry_pyri = 1'b0;
      @(negedge clk);
    end
    // retire edge just passed: the waiting instruction must not have been taken with it
    total++; if (wb_valid_pyro !== 1'b0 || inst_retry_pyro !== 1'b0)
      begin bad++; $display("FAIL wb_release got=%b %b exp=0 0", wb_valid_pyro, inst_retry_pyro); end
    @(negedge clk); idle_inputs();
    total++; if (wb_valid_pyro !== 1'b1 || wb_data_pyro !== 64'hBEEF || wb_rd_pyro !== 5'd10)
      begin bad++; $display("FAIL wb_next got=%b %h %0d exp=1 beef 10", wb_valid_pyro, wb_data_pyro, wb_rd_pyro); end
    @(negedge clk);
    // request stall, then reset while waiting for the response
    dmem_req_retry_pyri = 1'b1;
    present(64'h700, enc(7'b0000011, 3'b011), 64'h3000, 64'd4, 1'b1);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      total++; if (dmem_req_valid_pyro !== 1'b1 || dmem_addr_pyro !== 64'h3000 || inst_retry_pyro !== 1'b1)
        begin bad++; $display("FAIL req_stall cyc=%0d got=%b %h %b exp=1 3000 1", i, dmem_req_valid_pyro, dmem_addr_pyro, inst_retry_pyro); end
      if (i == 2) dmem_req_retry_pyri = 1'b0;
      @(negedge clk);
    end
    total++; if (dmem_resp_retry_pyro !== 1'b0 || dmem_req_valid_pyro !== 1'b0)
      begin bad++; $display("FAIL req_to_wait got=%b %b exp=0 0", dmem_resp_retry_pyro, dmem_req_valid_pyro); end
    reset_pyri = 1'b1; #1;
    total++; if (dmem_resp_retry_pyro !== 1'b1 || inst_retry_pyro !== 1'b1 || dmem_addr_pyro !== 64'd0 || wb_valid_pyro !== 1'b0 || wb_rd_pyro !== 5'd0)
      begin bad++; $display("FAIL wait_reset got=%b %b %h %b %0d exp=1 1 0 0 0", dmem_resp_retry_pyro, inst_retry_pyro, dmem_addr_pyro, wb_valid_pyro, wb_rd_pyro); end
    idle_inputs();
    @(negedge clk); reset_pyri = 1'b0;
    test_add(64'h77, 64'd0);
  endtask

  initial begin
    idle_inputs();
    pc_pyri = '0; inst_pyri = '0; rdata_pyri = '0; raddr_pyri = '0;
    dmem_req_retry_pyri = 1'b0; dmem_resp_valid_pyri = 1'b0; dmem_resp_data_pyri = '0;
    wb_retry_pyri = 1'b0; exc_retry_pyri = 1'b0;
    test_reset();
    test_add(64'h1234, 64'd5);
    test_load(3'b000, 64'h1003, 64'h0000_0000_80FF_0000, 64'hFFFF_FFFF_FFFF_FF80);
    test_load(3'b100, 64'h1003, 64'h0000_0000_80FF_0000, 64'h0000_0000_0000_0080);
    test_load(3'b001, 64'h1006, 64'h8001_0000_0000_0000, 64'hFFFF_FFFF_FFFF_8001);
    test_load(3'b110, 64'h1004, 64'hF234_5678_0000_0000, 64'h0000_0000_F234_5678);
    test_load(3'b011, 64'h1008, 64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF);
    test_store_sh();
    test_exception(7'b0000011, 3'b010, 64'h1002, 64'd1, 64'h1002);
    test_exception(7'b0100011, 3'b100, 64'h1, 64'h2000, 64'h2000);
    test_exception(7'b0000011, 3'b111, 64'h1000, 64'd1, 64'h1000);
    test_branch();
    test_backpressure();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end
endmodule
